// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master for PmodACL2 register accesses.
// One ncs_o low window carries 1..15 bytes, MSB first. SCLK half period is
// CLK_DIV clk cycles. MISO is sampled on SCLK rise and MOSI changes on SCLK fall.
//
// TX handshake: a byte moves when tx_valid && tx_ready are both high on a clk edge.
// tx_ready is high in IDLE, where the byte only matters together with start.
// Mid-transaction, tx_ready is high from the 8th SCLK rise of a byte that is
// followed by another, until that next byte has been taken.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_bytes,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       sclk_o,
  output logic       ncs_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_SHIFT   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_HOLD    = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  rem_q, rem_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        tx_req_q, tx_req_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        done_q, done_d;
  logic        tick;

  // Last cycle of the current half SCLK period.
  assign tick = (div_q == DIV_LAST);

  assign tx_ready    = !rst && ((state_q == S_IDLE) || tx_req_q);
  assign busy        = (state_q != S_IDLE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign done        = done_q;
  assign sclk_o      = sclk_q;
  assign ncs_o       = ncs_q;
  assign mosi_o      = mosi_q;
  assign dbg_state_o = state_q;

  // Next-state and datapath decisions for every state.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    rem_d      = rem_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_req_d   = tx_req_q;
    sclk_d     = sclk_q;
    ncs_d      = ncs_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d      = '0;
        bit_d      = '0;
        buf_full_d = 1'b0;
        tx_req_d   = 1'b0;
        if (start && tx_valid) begin
          if (num_bytes != 4'd0) begin
            tx_sh_d = tx_data;
            rem_d   = num_bytes;
            ncs_d   = 1'b0;
            mosi_d  = tx_data[7];
            state_d = S_SETUP;
          end else begin
            // Null transaction: byte is consumed, bus never moves.
            done_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso_i};
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        div_d = tick ? '0 : div_q + 8'd1;
        // Buffer the next byte as soon as the host offers it.
        if (tx_req_q && tx_valid) begin
          buf_d      = tx_data;
          buf_full_d = 1'b1;
          tx_req_d   = 1'b0;
        end
        if (tick && !sclk_q) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso_i};
          if (bit_q == 3'd7 && rem_q > 4'd1) tx_req_d = 1'b1;
        end else if (tick) begin
          sclk_d = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end else begin
            bit_d      = '0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            rem_d      = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              tx_req_d = 1'b0;
              state_d  = S_HOLD;
            end else if (buf_full_q) begin
              tx_sh_d    = buf_q;
              mosi_d     = buf_q[7];
              buf_full_d = 1'b0;
            end else if (tx_req_q && tx_valid) begin
              // Byte arrives exactly on the boundary: use it directly.
              tx_sh_d    = tx_data;
              mosi_d     = tx_data[7];
              buf_full_d = 1'b0;
            end else begin
              state_d = S_WAIT_TX;
            end
          end
        end
      end

      S_WAIT_TX: begin
        div_d = '0;
        if (tx_req_q && tx_valid) begin
          tx_sh_d  = tx_data;
          mosi_d   = tx_data[7];
          tx_req_d = 1'b0;
          state_d  = S_SETUP;
        end
      end

      S_HOLD: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          ncs_d   = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      rem_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_req_q   <= 1'b0;
      sclk_q     <= 1'b0;
      ncs_q      <= 1'b1;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      rem_q      <= rem_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_req_q   <= tx_req_d;
      sclk_q     <= sclk_d;
      ncs_q      <= ncs_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: SPI slave model, scoreboard queues for RX and
// MOSI bytes, directed and random transactions.
module tb_spi_master_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num_bytes = '0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       sclk_o;
  logic       ncs_o;
  logic       mosi_o;
  logic       miso_i = 1'b0;
  logic [2:0] dbg_state_o;

  spi_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .sclk_o(sclk_o), .ncs_o(ncs_o), .mosi_o(mosi_o), .miso_i(miso_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_mosi_q[$];
  logic [7:0] tx_b[16];
  logic [7:0] resp_b[16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and slave model, sampled on the falling clk edge
  int   low_cnt = 0, last_low_len = 0;
  int   done_tot = 0, rx_tot = 0, rise_tot = 0, ncs_fall_tot = 0, idle_bad = 0;
  logic rise_had_done = 1'b0;
  logic prev_sclk = 1'b0, prev_ncs = 1'b1;
  int   s_bit = 0, s_byte = 0, m_bits = 0;
  logic [7:0] m_sh = '0;
  logic [7:0] cur_b;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_tot++;
      if (exp_rx_q.size() == 0) check("rx_extra", exp_rx_q.size(), 1);
      else check("rx_data", rx_data, exp_rx_q.pop_front());
    end
    if (done) done_tot++;
    if (ncs_o && (mosi_o || sclk_o)) idle_bad++;
    if (!ncs_o) low_cnt++;
    if (prev_ncs && !ncs_o) begin
      ncs_fall_tot++;
      s_bit = 0; s_byte = 0; m_bits = 0;
    end
    if (!prev_ncs && ncs_o) begin
      last_low_len = low_cnt;
      low_cnt = 0;
      rise_had_done = done;
    end
    if (!ncs_o && !prev_sclk && sclk_o) begin
      rise_tot++;
      m_sh = {m_sh[6:0], mosi_o};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (exp_mosi_q.size() == 0) check("mosi_extra", exp_mosi_q.size(), 1);
        else check("mosi_byte", m_sh, exp_mosi_q.pop_front());
      end
    end
    if (!ncs_o && prev_sclk && !sclk_o) begin
      s_bit++;
      if (s_bit == 8) begin s_bit = 0; s_byte++; end
    end
    cur_b = (s_byte < 16) ? resp_b[s_byte] : 8'h00;
    miso_i = ncs_o ? 1'b0 : cur_b[7 - s_bit];
    prev_sclk = sclk_o;
    prev_ncs  = ncs_o;
  end

  // Driver: one transaction of n bytes from tx_b, slave answers from resp_b
  task automatic run_txn(input int n, input bit stall, input bit gap_start, input int exp_len);
    int d0, r0, s0, f0, k, wcnt, cyc;
    bit seen, fin;
    d0 = done_tot; r0 = rx_tot; s0 = rise_tot; f0 = ncs_fall_tot;
    for (int i = 0; i < n; i++) begin
      exp_rx_q.push_back(resp_b[i]);
      exp_mosi_q.push_back(tx_b[i]);
    end
    @(negedge clk);
    start = 1'b1; num_bytes = 4'(n); tx_data = tx_b[0]; tx_valid = 1'b1;
    k = 1; seen = 0; wcnt = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (seen) wcnt++;
      if (rx_valid) seen = 1;
      if (done) fin = 1;
      if (k < n && (!stall || k != 1 || (seen && wcnt >= 19))) begin
        tx_valid = 1'b1;
        tx_data  = tx_b[k];
        if (tx_ready) k++;
      end else begin
        tx_valid = 1'b0;
      end
    end
    check("txn_done_seen", fin, 1);
    if (n == 0) check("null_done_latency", cyc, 1);
    if (gap_start) begin
      f0 = ncs_fall_tot;
      start = 1'b1; num_bytes = 4'd1; tx_data = 8'h77; tx_valid = 1'b1;
      @(negedge clk);
      start = 1'b0; tx_valid = 1'b0;
    end
    repeat (CLK_DIV + 3) @(negedge clk);
    tx_valid = 1'b0;
    check("done_count", done_tot - d0, 1);
    check("rx_count", rx_tot - r0, n);
    check("sclk_rises", rise_tot - s0, 8 * n);
    check("busy_after", busy, 0);
    if (n > 0) begin
      check("ncs_low_len", last_low_len, exp_len);
      check("done_at_ncs_rise", rise_had_done, 1);
    end else begin
      check("null_ncs_falls", ncs_fall_tot - f0, 0);
    end
    if (gap_start) begin
      repeat (20) @(negedge clk);
      check("gap_start_ignored", ncs_fall_tot - f0, 0);
    end
  endtask

  initial begin
    int d0, r0, f0, cyc, n;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_ncs", ncs_o, 1);
    check("rst_sclk", sclk_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx_ready", tx_ready, 1);

    // Single byte: 0x0B out, 0xA5 back
    tx_b[0] = 8'h0B; resp_b[0] = 8'hA5;
    run_txn(1, 0, 0, 68);
    check("rx_data_held", rx_data, 8'hA5);

    // Three-byte read, no stall
    tx_b[0] = 8'h0B; tx_b[1] = 8'h08; tx_b[2] = 8'h00;
    resp_b[0] = 8'hFF; resp_b[1] = 8'hFF; resp_b[2] = 8'hAD;
    run_txn(3, 0, 0, 196);

    // Same with a 20-cycle host stall before byte 2
    run_txn(3, 1, 0, 216);

    // Null transaction
    run_txn(0, 0, 0, 0);

    // One byte, then start during GAP
    tx_b[0] = 8'h3C; resp_b[0] = 8'h5A;
    run_txn(1, 0, 1, 68);

    // Start without tx_valid in IDLE
    f0 = ncs_fall_tot;
    @(negedge clk);
    start = 1'b1; num_bytes = 4'd2; tx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("start_no_valid_ignored", ncs_fall_tot - f0, 0);
    check("start_no_valid_busy", busy, 0);

    // Random transactions
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        tx_b[i]   = 8'($urandom_range(0, 255));
        resp_b[i] = 8'($urandom_range(0, 255));
      end
      run_txn(n, 0, 0, CLK_DIV * (16 * n + 1));
    end

    // Reset after the 3rd SCLK rise of byte 1
    tx_b[0] = 8'hC3; resp_b[0] = 8'h96;
    d0 = done_tot; r0 = rx_tot; f0 = rise_tot; cyc = 0;
    @(negedge clk);
    start = 1'b1; num_bytes = 4'd3; tx_data = tx_b[0]; tx_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; tx_valid = 1'b0;
    while (rise_tot - f0 < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_3rd_rise", rise_tot - f0, 3);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ncs", ncs_o, 1);
    check("abort_sclk", sclk_o, 0);
    check("abort_busy", busy, 0);
    check("abort_rx_data", rx_data, 0);
    check("abort_done", done, 0);
    check("abort_rx_valid", rx_valid, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_tot - d0, 0);
    check("abort_no_rx", rx_tot - r0, 0);

    // Final
    check("exp_rx_q_empty", exp_rx_q.size(), 0);
    check("exp_mosi_q_empty", exp_mosi_q.size(), 0);
    check("idle_bus_quiet", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI mode-0 master that produces the serial bus signals `sclk_o`, `ncs_o` and `mosi_o`, and samples `miso_i`, for PmodACL2 register accesses. It runs multi-byte transactions: one `ncs_o` low window carries 1..15 bytes. On the host side it uses a valid/ready byte stream for TX data and a one-cycle `rx_valid` pulse per received byte. The byte-level SPI tracking stage sits directly downstream of it on the same `sclk_o`/`ncs_o` nets.

Parameters:
CLK_DIV, 4, number of `clk` cycles per half SCLK period (legal range 2..255).

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a transaction; honoured only in IDLE and only when `tx_valid`=1 in the same cycle
num_bytes  input  4  byte count for the transaction, sampled with `start`; 0 = null transaction
tx_data  input  8  next byte to transmit, MSB first
tx_valid  input  1  `tx_data` is valid
tx_ready  output  1  block will consume `tx_data` this cycle if `tx_valid`=1
rx_data  output  8  last received byte; held until the next byte completes
rx_valid  output  1  one-cycle pulse when `rx_data` updates
busy  output  1  high from the cycle after an accepted start until back in IDLE
done  output  1  one-cycle pulse at transaction end
sclk_o  output  1  SPI clock; idles low
ncs_o  output  1  SPI chip select, active-low; idles high
mosi_o  output  1  SPI data out; driven 0 while `ncs_o`=1
miso_i  input  1  SPI data in

Behaviour:
- Reset values (`rst`=1, takes effect at the next clk edge):
  - `ncs_o`=1, `sclk_o`=0, `mosi_o`=0.
  - `tx_ready`=0, `rx_data`=0x00, `rx_valid`=0, `busy`=0, `done`=0.
  - FSM returns to IDLE and all counters clear.
  - A reset mid-transaction aborts it: `ncs_o` rises on that edge, no `done`, no `rx_valid`.
- States: IDLE, SETUP, SHIFT, WAIT_TX, HOLD, GAP.
- IDLE:
  - `tx_ready`=1.
  - `start`&`tx_valid` with `num_bytes`≠0: latch `tx_data` into the shift register and `num_bytes` into the remaining-byte count; go to SETUP. Next cycle: `ncs_o`=0, `mosi_o`=bit 7, `busy`=1.
  - `start`&`tx_valid` with `num_bytes`=0: byte is consumed; `done` pulses the next cycle; `ncs_o` never falls; stay in IDLE.
  - `start` without `tx_valid`: ignored.
- SETUP: hold for CLK_DIV cycles, then raise `sclk_o` and enter SHIFT.
- SHIFT: a phase counter toggles `sclk_o` every CLK_DIV cycles.
  - Rising edge: shift `miso_i` into the RX shift register, MSB first.
  - Falling edge: present the next TX bit on `mosi_o`.
  - Bit counter 0..7 tracks the byte.
- `tx_ready` rises on the cycle of the 8th rising edge, only if more bytes remain. It stays high until the handshake completes; the accepted byte is buffered.
- 8th falling edge:
  - `rx_data` is updated and `rx_valid` pulses that cycle; the remaining count decrements.
  - Bytes remain and a buffered TX byte exists: load it, `mosi_o`=its bit 7, continue SHIFT with no gap.
  - Bytes remain and no buffered byte: go to WAIT_TX.
  - Count reaches 0: go to HOLD.
- WAIT_TX:
  - `sclk_o`=0 and `ncs_o`=0, held indefinitely.
  - On `tx_valid`&`tx_ready`: load the byte, `mosi_o`=bit 7, wait CLK_DIV cycles, then rise `sclk_o`.
- HOLD: `sclk_o`=0 for CLK_DIV cycles, then `ncs_o`=1 and `done` pulses in the same cycle; go to GAP.
- GAP: CLK_DIV cycles with `ncs_o` high, `busy` still 1, `tx_ready`=0; then IDLE with `busy`=0.
- Timing without stalls: `ncs_o` is low for CLK_DIV*(16*N+1) cycles, where N = bytes.
- `rx_valid` never asserts for a null transaction. `start` while `busy`=1 is ignored.

Test Plan:
- CLK_DIV=4; `start`, `num_bytes`=1, `tx_data`=0x0B, slave returns 0xA5 → 8 SCLK pulses; `mosi_o` shows 0,0,0,0,1,0,1,1; `rx_data`=0xA5 with one `rx_valid`; `ncs_o` low exactly 68 cycles; `done` on the `ncs_o` rise cycle.
- CLK_DIV=4; 3-byte read 0x0B,0x08,0x00 with `tx_valid` held high, slave returns 0xFF,0xFF,0xAD → `rx_valid` ×3 with 0xFF,0xFF,0xAD; `ncs_o` low 196 cycles; no SCLK gap between bytes.
- Same as above, but `tx_valid` dropped for 20 cycles before byte 2 → `sclk_o` stays low, `ncs_o` stays low; `ncs_o` low 216 cycles; data unchanged.
- `start` with `num_bytes`=0 → `done` pulse next cycle; `ncs_o` stays 1; no `rx_valid`.
- `rst` asserted after the 3rd SCLK rise of byte 1 → next edge: `ncs_o`=1, `sclk_o`=0, `busy`=0, `rx_data`=0x00; no `done`.
- `start` during GAP, and `start` with `tx_valid`=0 in IDLE → both ignored; `ncs_o` stays high.
